// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states,
// error codes and the default frame start marker.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// master = byte source (host or bench), slave = loader.
interface program_loader_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_byte, output in_valid, input in_ready);
  modport slave  (input in_byte, input in_valid, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Program loader: parses SYNC/LEN/DATA/CHK frames from a byte stream,
// writes assembled 16-bit words into instruction memory, and keeps the
// CPU in reset until a frame has loaded with a matching checksum.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          DEPTH     = 256,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic                clk,
  input  logic                pc_reset_n,
  program_loader_if.slave     s_in,
  input  logic                restart,
  output logic                imem_we,
  output logic [15:0]         imem_addr,
  output logic [15:0]         imem_wdata,
  output logic                cpu_hold,
  output logic                load_done,
  output logic [1:0]          err_code
);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  hi_q, hi_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  err_q, err_d;

  logic        ready;
  logic        accept;
  logic [15:0] new_len;
  logic [16:0] idx_inc;

  // Ready depends only on state so the source never sees a valid->ready loop.
  assign ready   = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept  = s_in.in_valid & ready;
  assign new_len = {len_q[15:8], s_in.in_byte};
  assign idx_inc = {1'b0, idx_q} + 17'd1;

  // Next-state, datapath and write-register updates for the frame parser.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chk_d   = chk_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept && s_in.in_byte == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          chk_d   = 8'h00;
          idx_d   = 16'h0000;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = s_in.in_byte;
          chk_d       = chk_q ^ s_in.in_byte;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = s_in.in_byte;
          chk_d      = chk_q ^ s_in.in_byte;
          if ({16'h0000, new_len} > 32'(DEPTH)) begin
            state_d = S_ERR;
            err_d   = ERR_LEN;
          end else if (new_len == 16'h0000) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = s_in.in_byte;
          chk_d   = chk_q ^ s_in.in_byte;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + idx_q;
          wdata_d = {hi_q, s_in.in_byte};
          chk_d   = chk_q ^ s_in.in_byte;
          idx_d   = idx_inc[15:0];
          state_d = (idx_inc < {1'b0, len_q}) ? S_DATA_HI : S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (s_in.in_byte == chk_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = ERR_CHK;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any pending write.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state_q <= S_IDLE;
      len_q   <= 16'h0000;
      idx_q   <= 16'h0000;
      chk_q   <= 8'h00;
      hi_q    <= 8'h00;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 16'h0000;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign s_in.in_ready = ready;
  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = (state_q != S_DONE);
  assign load_done     = (state_q == S_DONE);
  assign err_code      = err_q;

endmodule
